decode_stage: RTL

//  Decode stage of the 5-stage core. Sits between the f2d pipeline register and execute.

---
 rtl/decode_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage: ISA decode, 32x32 register file, immediate extension, load-use hazard detection, d2e register.
// Optional REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports instead of stalling.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     d_instr,
    input  logic [XLEN-1:0] d_pc,
    input  logic            d_valid,
    input  logic            w_en,
    input  logic [4:0]      w_reg,
    input  logic [XLEN-1:0] w_data,
    input  logic            e_flush,
    output logic            d_stall,
    output logic            e_valid,
    output logic [XLEN-1:0] e_pc,
    output logic [3:0]      e_op,
    output logic [4:0]      e_dst,
    output logic [XLEN-1:0] e_rs1_val,
    output logic [XLEN-1:0] e_rs2_val,
    output logic [XLEN-1:0] e_imm,
    output logic            e_illegal
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_LDB  = 4'd4,
        OP_LDW  = 4'd5,
        OP_STB  = 4'd6,
        OP_STW  = 4'd7,
        OP_BEQ  = 4'd8,
        OP_JUMP = 4'd9
    } op_e;

    logic [6:0] opc;
    logic [4:0] f_dst;
    logic [4:0] f_src1;
    logic [4:0] f_src2;

    assign opc    = d_instr[31:25];
    assign f_dst  = d_instr[24:20];
    assign f_src1 = d_instr[19:15];
    assign f_src2 = d_instr[14:10];

    op_e             dec_op;
    logic            dec_illegal;
    logic            use_a;
    logic            use_b;
    logic            is_store;
    logic            has_dst;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_dst;
    logic [4:0]      rs2_addr;

    always_comb begin
        dec_op      = OP_NOP;
        dec_illegal = 1'b0;
        use_a       = 1'b0;
        use_b       = 1'b0;
        is_store    = 1'b0;
        has_dst     = 1'b0;
        dec_imm     = '0;
        unique case (opc)
            7'h00: begin dec_op = OP_ADD; use_a = 1'b1; use_b = 1'b1; has_dst = 1'b1; end
            7'h01: begin dec_op = OP_SUB; use_a = 1'b1; use_b = 1'b1; has_dst = 1'b1; end
            7'h02: begin dec_op = OP_MUL; use_a = 1'b1; use_b = 1'b1; has_dst = 1'b1; end
            7'h10: begin
                dec_op  = OP_LDB;
                use_a   = 1'b1;
                has_dst = 1'b1;
                dec_imm = {{(XLEN-15){d_instr[14]}}, d_instr[14:0]};
            end
            7'h11: begin
                dec_op  = OP_LDW;
                use_a   = 1'b1;
                has_dst = 1'b1;
                dec_imm = {{(XLEN-15){d_instr[14]}}, d_instr[14:0]};
            end
            7'h12: begin
                dec_op   = OP_STB;
                use_a    = 1'b1;
                use_b    = 1'b1;
                is_store = 1'b1;
                dec_imm  = {{(XLEN-15){d_instr[14]}}, d_instr[14:0]};
            end
            7'h13: begin
                dec_op   = OP_STW;
                use_a    = 1'b1;
                use_b    = 1'b1;
                is_store = 1'b1;
                dec_imm  = {{(XLEN-15){d_instr[14]}}, d_instr[14:0]};
            end
            7'h30: begin
                dec_op  = OP_BEQ;
                use_a   = 1'b1;
                use_b   = 1'b1;
                dec_imm = {{(XLEN-15){d_instr[24]}}, d_instr[24:20], d_instr[9:0]};
            end
            7'h31: begin
                dec_op  = OP_JUMP;
                dec_imm = {{(XLEN-20){d_instr[24]}}, d_instr[24:20], d_instr[14:0]};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Stores carry their data register in the dst field, so port B is steered there.
    assign rs2_addr = is_store ? f_dst : f_src2;
    assign dec_dst  = has_dst ? f_dst : '0;

    logic [XLEN-1:0] rf_q [NREGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_q <= '{default: '0};
        end else if (w_en && (w_reg != '0)) begin
            rf_q[w_reg] <= w_data;
        end
    end

    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;

    always_comb begin
        rd_a = (f_src1 == '0) ? '0 : rf_q[f_src1];
        rd_b = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_en && (w_reg == f_src1) && (f_src1 != '0)) begin
            rd_a = w_data;
        end
        if (w_en && (w_reg == rs2_addr) && (rs2_addr != '0)) begin
            rd_b = w_data;
        end
`endif
    end

    logic            e_valid_q, e_valid_d;
    logic [XLEN-1:0] e_pc_q, e_pc_d;
    op_e             e_op_q, e_op_d;
    logic [4:0]      e_dst_q, e_dst_d;
    logic [XLEN-1:0] e_rs1_q, e_rs1_d;
    logic [XLEN-1:0] e_rs2_q, e_rs2_d;
    logic [XLEN-1:0] e_imm_q, e_imm_d;
    logic            e_illegal_q, e_illegal_d;

    logic load_use;
    logic wb_conflict;

    always_comb begin
        load_use = e_valid_q && ((e_op_q == OP_LDB) || (e_op_q == OP_LDW)) &&
                   (e_dst_q != '0) && d_valid &&
                   ((use_a && (f_src1 == e_dst_q)) || (use_b && (rs2_addr == e_dst_q)));
`ifdef REGFILE_BYPASS_EN
        wb_conflict = 1'b0;
`else
        // Without forwarding the read would see stale data, so hold one cycle until the write lands.
        wb_conflict = w_en && (w_reg != '0) && d_valid &&
                      ((use_a && (f_src1 == w_reg)) || (use_b && (rs2_addr == w_reg)));
`endif
    end

    assign d_stall = reset && !e_flush && (load_use || wb_conflict);

    always_comb begin
        e_valid_d   = 1'b0;
        e_pc_d      = '0;
        e_op_d      = OP_NOP;
        e_dst_d     = '0;
        e_rs1_d     = '0;
        e_rs2_d     = '0;
        e_imm_d     = '0;
        e_illegal_d = 1'b0;
        if (d_valid && !e_flush && !d_stall) begin
            e_valid_d   = 1'b1;
            e_pc_d      = d_pc;
            e_op_d      = dec_op;
            e_dst_d     = dec_dst;
            e_rs1_d     = rd_a;
            e_rs2_d     = rd_b;
            e_imm_d     = dec_imm;
            e_illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e_valid_q   <= 1'b0;
            e_pc_q      <= '0;
            e_op_q      <= OP_NOP;
            e_dst_q     <= '0;
            e_rs1_q     <= '0;
            e_rs2_q     <= '0;
            e_imm_q     <= '0;
            e_illegal_q <= 1'b0;
        end else begin
            e_valid_q   <= e_valid_d;
            e_pc_q      <= e_pc_d;
            e_op_q      <= e_op_d;
            e_dst_q     <= e_dst_d;
            e_rs1_q     <= e_rs1_d;
            e_rs2_q     <= e_rs2_d;
            e_imm_q     <= e_imm_d;
            e_illegal_q <= e_illegal_d;
        end
    end

    assign e_valid   = e_valid_q;
    assign e_pc      = e_pc_q;
    assign e_op      = e_op_q;
    assign e_dst     = e_dst_q;
    assign e_rs1_val = e_rs1_q;
    assign e_rs2_val = e_rs2_q;
    assign e_imm     = e_imm_q;
    assign e_illegal = e_illegal_q;

endmodule
